// File: rtl/pow_pkg.sv
// Shared definitions for the pow_sqm exponentiation unit and its multiplier.
// Holds the controller state enum, the default operand/result widths, and the
// width helper for the multiplier's iteration counter.
package pow_pkg;

  localparam int unsigned POW_A_WIDTH_DEF = 32;
  localparam int unsigned POW_B_WIDTH_DEF = 32;
  localparam int unsigned POW_RW_DEF      = 64;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    SQR,
    NEXT,
    DONE
  } pow_state_e;

  // Counter must hold 0 .. rw-1.
  function automatic int unsigned cnt_width(input int unsigned rw);
    return (rw <= 1) ? 1 : $clog2(rw);
  endfunction

endpackage

// File: rtl/pow_sqm_mul_shift_add.sv
// mul_shift_add: sequential shift-add multiplier, one multiplier bit per cycle.
//   Clk, Rst   : clock, synchronous active-high reset (clears all state)
//   start      : load a/b and begin; restarts if asserted while running
//   a, b       : RW-bit operands
//   p          : low RW bits of a*b, valid while done is high
//   done       : one-cycle pulse RW cycles after start is sampled
//   ovf        : high half of the true product is nonzero (valid with done)
// With POW_SQM_OVF_DETECT_EN defined the accumulator is 2*RW bits so overflow
// can be seen; otherwise it is RW bits and ovf is constant 0.
module mul_shift_add
  import pow_pkg::*;
#(
  parameter int unsigned RW = POW_RW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] p,
  output logic          done,
  output logic          ovf
);

  localparam int unsigned CW = cnt_width(RW);
`ifdef POW_SQM_OVF_DETECT_EN
  localparam int unsigned AW = 2 * RW;
`else
  localparam int unsigned AW = RW;
`endif

  logic [AW-1:0] acc;
  logic [AW-1:0] mcand;
  logic [RW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= AW'(a);
        mplier <= b;
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // Final iteration: accumulator update and done land on the same edge.
        if (cnt == CW'(RW - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = acc[RW-1:0];

`ifdef POW_SQM_OVF_DETECT_EN
  assign ovf = |acc[AW-1:RW];
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pow_sqm.sv
// pow_sqm: R = A^B (mod 2^RW) by LSB-first square-and-multiply.
//   Clk, Rst : clock, synchronous active-high reset
//   start    : request, sampled only while idle; A/B captured on acceptance
//   A, B     : base (A_WIDTH) and exponent (B_WIDTH)
//   R        : result register, held from ack until the next accepted start
//   ack      : one-cycle completion pulse
//   busy     : high from the cycle after acceptance through the ack cycle
//   ovf      : sticky overflow for the current operation, valid with ack
// Optional feature: POW_SQM_OVF_DETECT_EN enables overflow detection in the
// multiplier; without it the multiplier never reports overflow, so ovf stays 0.
module pow_sqm
  import pow_pkg::*;
#(
  parameter int unsigned A_WIDTH = POW_A_WIDTH_DEF,
  parameter int unsigned B_WIDTH = POW_B_WIDTH_DEF,
  parameter int unsigned RW      = POW_RW_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  output logic [RW-1:0]      R,
  output logic               ack,
  output logic               busy,
  output logic               ovf
);

  pow_state_e state, state_n;

  logic [B_WIDTH-1:0] e;
  logic [B_WIDTH-1:0] e_shr;
  logic [RW-1:0]      xb;
  logic               ovf_q;

  logic               m_start;
  logic [RW-1:0]      m_a;
  logic [RW-1:0]      m_b;
  logic [RW-1:0]      m_p;
  logic               m_done;
  logic               m_ovf;

  assign e_shr = e >> 1;

  mul_shift_add #(.RW(RW)) u_mul (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (m_start),
    .a     (m_a),
    .b     (m_b),
    .p     (m_p),
    .done  (m_done),
    .ovf   (m_ovf)
  );

  always_comb begin
    state_n = state;
    m_start = 1'b0;
    m_a     = R;
    m_b     = xb;
    unique case (state)
      IDLE:  if (start) state_n = CHECK;
      CHECK: begin
        if (e == '0) begin
          state_n = DONE;
        end else if (e[0]) begin
          m_start = 1'b1;
          state_n = MUL;
        end else begin
          state_n = NEXT;
        end
      end
      MUL:   if (m_done) state_n = NEXT;
      // Decision uses the shifted exponent so the final squaring is skipped.
      NEXT: begin
        if (e_shr == '0) begin
          state_n = DONE;
        end else begin
          m_start = 1'b1;
          m_a     = xb;
          state_n = SQR;
        end
      end
      SQR:   if (m_done) state_n = CHECK;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      R     <= '0;
      e     <= '0;
      xb    <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            e     <= B;
            xb    <= RW'(A);
            R     <= RW'(1);
            ovf_q <= 1'b0;
          end
        end
        MUL: begin
          if (m_done) begin
            R     <= m_p;
            ovf_q <= ovf_q | m_ovf;
          end
        end
        SQR: begin
          if (m_done) begin
            xb    <= m_p;
            ovf_q <= ovf_q | m_ovf;
          end
        end
        NEXT:    e <= e_shr;
        default: ;
      endcase
    end
  end

  assign ack  = (state == DONE);
  assign busy = (state != IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pow_sqm.sv
// Bench for pow_sqm: two instances (RW=64 and RW=16) with directed vectors.
module tb_pow_sqm;

  logic        Clk;
  logic        rst [2];
  logic        st  [2];
  logic [31:0] av  [2];
  logic [31:0] bv  [2];

  logic [63:0] r0;
  logic [15:0] r1;
  logic        ack0, ack1, busy0, busy1, ovf0, ovf1;

  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;

  // Driver -> compare handoff
  int          run_id   [2] = '{0, 0};
  int          abort_id [2] = '{0, 0};
  logic [63:0] exp_r    [2];
  logic        exp_ovf  [2];
  int          exp_lat  [2];

  // Owned by the compare process
  int          seen_run   [2] = '{0, 0};
  int          seen_abort [2] = '{0, 0};
  logic        active     [2] = '{1'b0, 1'b0};
  int          cyc        [2] = '{0, 0};
  logic [63:0] held       [2] = '{64'd0, 64'd0};
  logic [63:0] got_r      [2];
  int          got_lat    [2];

  pow_sqm #(.A_WIDTH(32), .B_WIDTH(32), .RW(64)) u_w64 (
    .Clk(Clk), .Rst(rst[0]), .start(st[0]), .A(av[0]), .B(bv[0]),
    .R(r0), .ack(ack0), .busy(busy0), .ovf(ovf0)
  );

  pow_sqm #(.A_WIDTH(16), .B_WIDTH(8), .RW(16)) u_w16 (
    .Clk(Clk), .Rst(rst[1]), .start(st[1]), .A(av[1][15:0]), .B(bv[1][7:0]),
    .R(r1), .ack(ack1), .busy(busy1), .ovf(ovf1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int i,
                       input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               name, i, got, got, want, want, $time);
    end
  endtask

  // Reference: A^B mod 2^rw with overflow of any true product, and latency
  // from bit length / popcount of B.
  task automatic model(input logic [63:0] a, input logic [63:0] b,
                       input int unsigned rw, output logic [63:0] r,
                       output logic ov, output int lat);
    logic [127:0] mask, x, acc, t;
    logic [63:0]  ee;
    int           k, p;
    mask = (128'd1 << rw) - 128'd1;
    x = {64'd0, a}; acc = 128'd1; ee = b; ov = 1'b0; k = 0; p = 0;
    for (logic [63:0] tmp = b; tmp != 0; tmp = tmp >> 1) begin
      k++;
      if (tmp[0]) p++;
    end
    lat = (b == 0) ? 2 : 1 + 2 * k + (p + k - 1) * (int'(rw) + 1);
    while (ee != 0) begin
      if (ee[0]) begin
        t = acc * x;
        if ((t & ~mask) != 0) ov = 1'b1;
        acc = t & mask;
      end
      ee = ee >> 1;
      if (ee != 0) begin
        t = x * x;
        if ((t & ~mask) != 0) ov = 1'b1;
        x = t & mask;
      end
    end
    r = acc[63:0];
  endtask

  // Per-cycle compare against the expectations published by the driver.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin : cmp
      logic [63:0] rv;
      logic        ak, bz, ov;
      rv = (i == 0) ? r0 : {48'd0, r1};
      ak = (i == 0) ? ack0 : ack1;
      bz = (i == 0) ? busy0 : busy1;
      ov = (i == 0) ? ovf0 : ovf1;
      if (abort_id[i] != seen_abort[i]) begin
        seen_abort[i] = abort_id[i];
        active[i] = 1'b0;
        held[i] = 64'd0;
      end
      if (run_id[i] != seen_run[i]) begin
        seen_run[i] = run_id[i];
        active[i] = 1'b1;
        cyc[i] = 0;
        got_r[i] = '1;
        got_lat[i] = -1;
      end
      if (chk_en) begin
        if (active[i]) begin
          cyc[i]++;
          check("busy", i, {63'd0, bz}, 64'd1);
          check("ack", i, {63'd0, ak}, {63'd0, cyc[i] == exp_lat[i]});
          if (ak && got_lat[i] < 0) begin
            got_lat[i] = cyc[i];
            got_r[i] = rv;
          end
          if (cyc[i] >= exp_lat[i]) begin
            check("R", i, rv, exp_r[i]);
            check("ovf", i, {63'd0, ov}, {63'd0, exp_ovf[i]});
            held[i] = exp_r[i];
            active[i] = 1'b0;
          end
        end else begin
          check("idle_ack", i, {63'd0, ak}, 64'd0);
          check("idle_busy", i, {63'd0, bz}, 64'd0);
          check("idle_R", i, rv, held[i]);
        end
      end
    end
  end

  // mode 0: plain run; 1: ignored start mid-run; 2: Rst in cycle 40
  task automatic run(input int i, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] lit_r, input logic lit_ovf,
                     input int lit_lat, input int mode);
    logic [63:0] mr;
    logic        mo;
    int          ml;
    bit          aborted;
    aborted = 0;
    @(negedge Clk);
    st[i] = 1'b1; av[i] = a; bv[i] = b;
    @(posedge Clk);
    #1;
    st[i] = 1'b0;
    model({32'd0, a}, {32'd0, b}, (i == 0) ? 64 : 16, mr, mo, ml);
    check("model_R", i, mr, lit_r);
    check("model_ovf", i, {63'd0, mo}, {63'd0, lit_ovf});
    check("model_lat", i, 64'(ml), 64'(lit_lat));
    exp_r[i] = mr;
`ifdef POW_SQM_OVF_DETECT_EN
    exp_ovf[i] = mo;
`else
    exp_ovf[i] = 1'b0;
`endif
    exp_lat[i] = ml;
    av[i] = $urandom;
    bv[i] = $urandom;
    run_id[i]++;
    for (int n = 0; n < 6000; n++) begin
      @(negedge Clk);
      #1;
      if (mode == 1) begin
        st[i] = (cyc[i] == 10);
        if (cyc[i] == 10) begin av[i] = 32'd7; bv[i] = 32'd2; end
      end
      if (mode == 2 && cyc[i] == 40) begin
        rst[i] = 1'b1;
        @(posedge Clk);
        #1;
        rst[i] = 1'b0;
        abort_id[i]++;
        aborted = 1;
        break;
      end
      if (!active[i]) break;
    end
    st[i] = 1'b0;
    if (!aborted) begin
      check("completed", i, {63'd0, active[i]}, 64'd0);
      check("R_lit", i, got_r[i], lit_r);
      check("lat_lit", i, 64'(got_lat[i]), 64'(lit_lat));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    repeat (3) @(posedge Clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check("rst_ovf", 0, {63'd0, ovf0}, 64'd0);
    check("rst_ovf", 1, {63'd0, ovf1}, 64'd0);
    check("rst_R", 0, r0, 64'd0);
    check("rst_R", 1, {48'd0, r1}, 64'd0);
    chk_en = 1'b1;

    run(0, 32'd2,     32'd8,  64'd256, 1'b0, 269, 0);
    run(0, 32'd0,     32'd0,  64'd1,   1'b0, 2,   0);
    run(0, 32'd12345, 32'd0,  64'd1,   1'b0, 2,   0);
    run(0, 32'd3,     32'd40, 64'd12157665459056928801, 1'b0, 468, 0);

    run(1, 32'd3,   32'd5,   64'd243,   1'b0, 75,  1);
    repeat (3) @(negedge Clk);
    run(1, 32'd256, 32'd2,   64'd0,     1'b1, 39,  0);
    run(1, 32'd3,   32'd11,  64'd46075, 1'b1, 111, 0);
    run(1, 32'd0,   32'd7,   64'd0,     1'b0, 92,  0);
    run(1, 32'd1,   32'd255, 64'd1,     1'b0, 272, 0);
    run(1, 32'd3,   32'd5,   64'd243,   1'b0, 75,  2);
    repeat (2) @(negedge Clk);
    run(1, 32'd2,   32'd3,   64'd8,     1'b0, 56,  0);
    run(1, 32'd5,   32'd3,   64'd125,   1'b0, 56,  0);

    // Rst and start together: reset must win, unit stays idle.
    @(negedge Clk);
    rst[1] = 1'b1; st[1] = 1'b1; av[1] = 32'd9; bv[1] = 32'd2;
    @(posedge Clk);
    #1;
    rst[1] = 1'b0; st[1] = 1'b0;
    abort_id[1]++;
    repeat (4) @(negedge Clk);
    run(1, 32'd2,   32'd3,   64'd8,     1'b0, 56,  0);
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pow_sqm.md
# pow_sqm

Parametrised integer exponentiation unit computing R = A^B by LSB-first square-and-multiply, replacing the repeated-multiplication power block and its repeated-addition multiplier. It uses the same start/ack handshake towards its controller, adds a busy flag, a synchronous reset and optional overflow detection. Internally it drives one shift-add multiplier, which is also usable on its own.

## Interface
- `A_WIDTH`, default 32: base operand width.
- `B_WIDTH`, default 32: exponent operand width.
- `RW`, default 64: result and multiplier width, with RW ≥ A_WIDTH. Results are taken modulo 2^RW.
- `Clk`, input, 1: the single clock; all state changes on the rising edge.
- `Rst`, input, 1: synchronous reset, active-high.
- `start`, input, 1: request. Sampled only in IDLE.
- `A`, input, A_WIDTH: base, captured when `start` is accepted.
- `B`, input, B_WIDTH: exponent, captured when `start` is accepted.
- `R`, output, RW: result register. Held from `ack` until the next accepted `start`.
- `ack`, output, 1: one-cycle completion pulse.
- `busy`, output, 1: high from the cycle after acceptance through the DONE cycle, inclusive.
- `ovf`, output, 1: sticky overflow flag for the current operation. Valid with `ack`.

## Operation
- Registers:
  - E: B_WIDTH bits, the exponent.
  - Xb: RW bits, the running square.
  - R: RW bits, the accumulated result.
- States and transitions:
  - IDLE: when `start`=1, load E←B, Xb←zero-extended A, R←1, ovf←0, then go to CHECK. When `start`=0, stay in IDLE.
  - CHECK:
    - If E==0, go to DONE. This only occurs for B=0.
    - Else if E[0]=1, issue a multiply R×Xb and go to MUL.
    - Otherwise go to NEXT.
  - MUL: wait for the multiplier's `done`. On `done`, R←product, then go to NEXT.
  - NEXT: E←E>>1.
    - If the shifted E is 0, go to DONE.
    - Otherwise issue a multiply Xb×Xb and go to SQR.
    - The final squaring is never performed.
  - SQR: on `done`, Xb←product, then go to CHECK.
  - DONE: `ack`=1 for exactly this cycle, then go to IDLE.
- Overflow: `ovf` is set in MUL or SQR when the true product is ≥ 2^RW. R still receives the low RW bits.
- Boundary cases:
  - B=0 gives R=1 for every A, including A=0.
  - A=0 with B>0 gives R=0 and ovf=0.
  - A=1 never overflows.
- `start` while `busy` is ignored and does not queue.
- `A` and `B` may change after acceptance without effect.

## Timing
- Reset values: R=0, ack=0, busy=0, ovf=0, state IDLE. All multiplier state is cleared.
- `Rst` mid-operation aborts on the next edge. There is no `ack`, and any multiplier result still in flight is discarded.
- Multiplier latency: the issue cycle plus RW iteration cycles, so MUL and SQR each last exactly RW+1 cycles.
- Latency, counted from the edge that accepts `start` (cycle 0):
  - B=0: DONE and `ack` occur in cycle 2.
  - Otherwise, with k = bit length of B and p = popcount(B): `ack` occurs in cycle 1 + 2k + (p+k−1)(RW+1).
- The earliest next `start` is sampled in the cycle after `ack`.
- `Rst` and `start` asserted in the same cycle: `Rst` wins.

## Configuration
- `POW_SQM_OVF_DETECT_EN`
  - Defined: the multiplier keeps a 2·RW-bit accumulator and reports high-half-nonzero, and `ovf` is driven as specified.
  - Undefined: the accumulator is RW bits only, and `ovf` is tied to 0.
  - R, state sequence and latency are identical in both builds.

## Structure
- Shared package `pow_pkg`:
  - State enum: IDLE, CHECK, MUL, SQR, NEXT, DONE.
  - Default width constants.
  - A `clog2`-based iteration-counter width.
- Sub-module `mul_shift_add #(RW)`:
  - Ports: Clk, Rst, start, a[RW], b[RW], p[RW], done, ovf.
  - Handles one multiplier bit per cycle.
  - `done` is a one-cycle pulse RW cycles after `start` is sampled, with p and ovf valid in the same cycle.
  - `pow_sqm` instantiates exactly one.

## Test plan
- RW=64, A=2, B=8 → R=256, ovf=0, `ack` in cycle 269, one-cycle pulse, `busy` falls after it.
- RW=16, A=3, B=5 → R=243 with `ack` in cycle 75; a `start` pulsed mid-run with A=7 is ignored.
- B=0 with A=0, then with A=12345 → R=1 both times, `ack` in cycle 2, ovf=0.
- RW=16, A=256, B=2 → R=0 with ovf=1. Without `POW_SQM_OVF_DETECT_EN`, same R with ovf=0.
- `Rst` asserted in cycle 40 of an A=3, B=5 run → next cycle R=0, busy=0, ack=0. A fresh start with A=2, B=3 then returns R=8.
- Back-to-back: `start` in the cycle after `ack` is accepted, and the previous R stays held until that acceptance edge.
